cdc_hs_arbiter: RTL and testbench

Source-domain arbiter that shares one CDC handshake synchronizer (2-phase or 4-phase variant) among N_REQ requesters. It sits in the `i_clk` domain in front of the synchronizer's `i_valid`/`i_data`/`busy` port. It picks requesters round-robin and tags each word with the winner's ID so the destination side can demultiplex. It issues a single-cycle valid pulse only when the synchronizer is idle, then tracks `busy` until the transfer completes.

---
 rtl/cdc_hs_arbiter.sv | 111 +++++++++++
 tb/tb_cdc_hs_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin arbiter sharing one CDC handshake synchronizer among N_REQ requesters,
// tagging each word with the winner's ID and tracking busy with a timeout.
module cdc_hs_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int BUSY_TO = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      s_valid,
    output logic [ID_W+DATA_W-1:0]    s_data,
    input  logic                      s_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [CNT_W-1:0]          xfer_cnt,
    output logic                      timeout_err
);
    typedef enum logic [1:0] {IDLE, SEND, HOLD, DRAIN} state_t;
    localparam int NP = 2 ** ID_W;
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [ID_W:0] NR = (ID_W + 1)'(N_REQ);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win;
    logic [ID_W+DATA_W-1:0]  s_data_q, s_data_d;
    logic [CNT_W-1:0]        xfer_cnt_q, xfer_cnt_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [NP-1:0]           valid_pad;
    logic [ID_W:0]           sum, nxt;
    logic                    grant;

    assign valid_pad = NP'(req_valid);
    assign grant = state_q == IDLE && !s_busy && |req_valid && !i_rst;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        win = '0;
        sum = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            sum = sum >= NR ? sum - NR : sum;
            if (valid_pad[sum[ID_W-1:0]]) win = sum[ID_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            s_data_q      <= '0;
            xfer_cnt_q    <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            s_data_q      <= s_data_d;
            xfer_cnt_q    <= xfer_cnt_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        s_data_d      = s_data_q;
        xfer_cnt_d    = xfer_cnt_q;
        to_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        nxt           = {1'b0, win} + 1'b1;
        case (state_q)
            IDLE: if (grant) begin
                state_d    = SEND;
                rr_ptr_d   = nxt >= NR ? '0 : nxt[ID_W-1:0];
                grant_id_d = win;
                s_data_d   = {win, req_data[win*DATA_W +: DATA_W]};
            end
            SEND: state_d = HOLD;
            HOLD: if (s_busy) begin
                state_d    = DRAIN;
                xfer_cnt_d = xfer_cnt_q + 1'b1;
            end else if (to_cnt_q == TW'(BUSY_TO - 1)) begin
                state_d       = IDLE;
                timeout_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
            DRAIN: state_d = s_busy ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant ? N_REQ'(1) << win : '0;
        s_valid   = state_q == SEND;
    end

    assign s_data      = s_data_q;
    assign grant_id    = grant_id_q;
    assign xfer_cnt    = xfer_cnt_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb_cdc_hs_arbiter: randomized scoreboard bench with a behavioural synchronizer and round-robin model.
module tb_cdc_hs_arbiter;
    localparam int N = 4, DW = 8, IW = 2, TO = 8, CW = 4;

    logic clk = 1'b0, rst = 1'b1, s_busy = 1'b0, s_valid, timeout_err;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [IW+DW-1:0] s_data;
    logic [IW-1:0] grant_id;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] mcnt = '0;
    logic drop = 1'b0, keep = 1'b0;
    int checks = 0, errors = 0, cyc = 0, busy_len = 2, acc_cnt = 0;
    int last_acc = -100, ptr = 0;
    logic [IW+DW-1:0] expq[$];
    int gq[$];

    cdc_hs_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .BUSY_TO(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .s_valid(s_valid), .s_data(s_data), .s_busy(s_busy),
        .grant_id(grant_id), .xfer_cnt(xfer_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int getg(input int i);
        return i < gq.size() ? gq[i] : -1;
    endfunction

    // Monitor: round-robin reference on accept, scoreboard pop on s_valid.
    initial begin : mon
        int w;
        logic [IW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ptr = 0;
                last_acc = -100;
                expq.delete();
            end else begin
                if (req_ready != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
                    chk("grant_winner", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
                    chk("grant_while_busy", 32'(s_busy), 0);
                    chk("grant_gap_ge4", 32'(cyc - last_acc >= 4), 1);
                    if (w >= 0) begin
                        expq.push_back({w[IW-1:0], req_data[w*DW +: DW]});
                        gq.push_back(w);
                        ptr = (w + 1) % N;
                    end
                    last_acc = cyc;
                end
                if (s_valid) begin
                    chk("valid_latency", cyc - last_acc, 1);
                    chk("valid_while_busy", 32'(s_busy), 0);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got s_data 0x%0h expected no pulse", s_data);
                    end else begin
                        e = expq.pop_front();
                        chk("s_data", 32'(s_data), 32'(e));
                        chk("grant_id", 32'(grant_id), 32'(e[IW+DW-1:DW]));
                    end
                end
            end
        end
    end

    // Synchronizer model: busy rises 0..2 cycles into HOLD, stays high busy_len cycles.
    initial begin : sync
        int d;
        forever begin
            @(negedge clk);
            if (rst) mcnt = '0;
            else if (s_valid && !drop) begin
                d = $urandom_range(0, 2);
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1 s_busy = 1'b1;
                mcnt++;
                for (int i = 0; i < busy_len; i++) begin
                    @(posedge clk);
                    if (rst) mcnt = '0;
                end
                #1 s_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        logic [N-1:0] a;
        @(negedge clk);
        a = req_ready;
        @(posedge clk);
        #1;
        if (a != '0) acc_cnt++;
        if (!keep) req_valid &= ~a;
    endtask

    task automatic issue(input int k, input logic [DW-1:0] d);
        req_data[k*DW +: DW] = d;
        req_valid[k] = 1'b1;
    endtask

    task automatic run_accepts(input int n, input string name);
        int b = 0;
        acc_cnt = 0;
        while (acc_cnt < n && b < 400) begin
            step();
            b++;
        end
        chk({name, "_accepts"}, acc_cnt, n);
    endtask

    task automatic drain();
        repeat (16) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_req_ready"}, 32'(req_ready), 0);
        chk({name, "_s_valid"}, 32'(s_valid), 0);
        chk({name, "_s_data"}, 32'(s_data), 0);
        chk({name, "_grant_id"}, 32'(grant_id), 0);
        chk({name, "_xfer_cnt"}, 32'(xfer_cnt), 0);
        chk({name, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    initial begin
        int g0, b, k, issued;
        step();
        step();
        chk_reset_vals("por");
        rst = 1'b0;

        // single request
        g0 = gq.size();
        issue(0, 8'h5A);
        run_accepts(1, "single");
        drain();
        chk("single_id", getg(g0), 0);
        chk("single_cnt", 32'(xfer_cnt), 1);

        // all four held valid
        do_reset();
        g0 = gq.size();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = '1;
        keep = 1'b1;
        run_accepts(8, "rr");
        keep = 1'b0;
        req_valid = '0;
        drain();
        for (int i = 0; i < 8; i++) chk("rr_order", getg(g0 + i), i % 4);
        chk("rr_cnt", 32'(xfer_cnt), 8);

        // preload 2, then 1 and 3
        do_reset();
        g0 = gq.size();
        issue(2, 8'h22);
        run_accepts(1, "pre2");
        issue(1, 8'h11);
        issue(3, 8'h33);
        run_accepts(2, "pre13");
        drain();
        chk("pre_order0", getg(g0), 2);
        chk("pre_order1", getg(g0 + 1), 3);
        chk("pre_order2", getg(g0 + 2), 1);

        // randomized 17 transfers, counter wraps at 16
        do_reset();
        issued = 0;
        acc_cnt = 0;
        b = 0;
        while (acc_cnt < 17 && b < 2000) begin
            if (issued < 17) begin
                k = $urandom_range(0, N - 1);
                if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
                    issue(k, 8'($urandom));
                    issued++;
                end
            end
            busy_len = $urandom_range(1, 4);
            step();
            b++;
        end
        chk("rand_accepts", acc_cnt, 17);
        drain();
        chk("wrap_cnt", 32'(xfer_cnt), 1);
        chk("model_cnt", 32'(xfer_cnt), 32'(mcnt));

        // reset during DRAIN with xfer_cnt=5
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 4; i++) begin
            issue(i, 8'(8'h60 + i));
            run_accepts(1, "pre_rst");
            drain();
        end
        busy_len = 20;
        issue(2, 8'h77);
        run_accepts(1, "rst_xfer");
        b = 0;
        while (!s_busy && b < 10) begin
            step();
            b++;
        end
        step();
        chk("drain_cnt", 32'(xfer_cnt), 5);
        rst = 1'b1;
        step();
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        g0 = gq.size();
        issue(1, 8'h11);
        issue(3, 8'h33);
        acc_cnt = 0;
        b = 0;
        while (s_busy && b < 60) begin
            step();
            b++;
        end
        chk("no_grant_while_busy", acc_cnt, 0);
        busy_len = 2;
        run_accepts(2, "post_rst");
        drain();
        chk("post_rst_order0", getg(g0), 1);
        chk("post_rst_order1", getg(g0 + 1), 3);
        chk("post_rst_cnt", 32'(xfer_cnt), 2);

        // busy never rises: timeout
        drop = 1'b1;
        issue(0, 8'hE0);
        acc_cnt = 0;
        b = 0;
        while (acc_cnt == 0 && b < 50) begin
            step();
            b++;
        end
        chk("to_accepts", acc_cnt, 1);
        repeat (9) @(negedge clk);
        chk("to_not_yet", 32'(timeout_err), 0);
        @(negedge clk);
        chk("to_set", 32'(timeout_err), 1);
        chk("to_cnt_kept", 32'(xfer_cnt), 2);
        @(posedge clk);
        #1 drop = 1'b0;
        issue(1, 8'hE1);
        run_accepts(1, "after_to");
        drain();
        chk("after_to_cnt", 32'(xfer_cnt), 3);
        chk("to_sticky", 32'(timeout_err), 1);
        chk("after_to_scoreboard_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
